// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel/line position from sync edges, verifies timing,
// and streams active RGB444 pixels into a linear frame buffer once locked.
module vga_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [7:0]        r,
    input  logic [7:0]        g,
    input  logic [7:0]        b,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_done,
    output logic              locked,
    output logic [7:0]        err_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_FIRST   = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_LASTPX  = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_FIRST   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_LASTLN  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [10:0] H_LEN_OK  = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LEN_OK  = 10'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t            state;
    logic              s1_hs, s1_vs, s2_hs, s2_vs;
    logic [3:0]        s1_r, s1_g, s1_b;
    logic [10:0]       h_cnt;
    logic [9:0]        v_cnt;
    logic              vs_pend;
    logic [ADDR_W-1:0] addr_nxt;

    logic              hs_fall, vs_fall, frame_evt, chk_fail, active;
    logic [11:0]       hpos;
    logic              unused_lsb;

    // Only the upper nibble of each colour reaches the frame buffer.
    assign unused_lsb = ^{r[3:0], g[3:0], b[3:0]};

    always_comb begin
        hs_fall   = s2_hs & ~s1_hs;
        vs_fall   = s2_vs & ~s1_vs;
        frame_evt = hs_fall & (vs_fall | vs_pend);
        chk_fail  = hs_fall & ((h_cnt != H_LEN_OK) | (frame_evt & (v_cnt != V_LEN_OK)));
        // h_cnt lags the s1 sample by one; hpos is the line position of the s1 pixel.
        hpos      = {1'b0, h_cnt} + 12'd1;
        active    = ~hs_fall
                  && (hpos >= H_FIRST) && (hpos <= H_LASTPX)
                  && (v_cnt >= V_FIRST) && (v_cnt <= V_LASTLN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s2_hs   <= 1'b1;
            s2_vs   <= 1'b1;
            s1_r    <= '0;
            s1_g    <= '0;
            s1_b    <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            vs_pend <= 1'b0;
        end else begin
            s1_hs <= hsync;
            s1_vs <= vsync;
            s2_hs <= s1_hs;
            s2_vs <= s1_vs;
            s1_r  <= r[7:4];
            s1_g  <= g[7:4];
            s1_b  <= b[7:4];

            if (hs_fall)
                h_cnt <= '0;
            else if (h_cnt != '1)
                h_cnt <= h_cnt + 1'b1;

            if (hs_fall) begin
                vs_pend <= 1'b0;
                if (vs_fall || vs_pend)
                    v_cnt <= '0;
                else if (v_cnt != '1)
                    v_cnt <= v_cnt + 1'b1;
            end else if (vs_fall) begin
                vs_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            err_cnt    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            addr_nxt   <= '0;
        end else begin
            frame_done <= 1'b0;
            wr_en      <= 1'b0;

            case (state)
                SEARCH: begin
                    if (frame_evt)
                        state <= MEASURE;
                end
                MEASURE: begin
                    if (chk_fail) begin
                        state <= SEARCH;
                    end else if (frame_evt) begin
                        state      <= LOCKED;
                        locked     <= 1'b1;
                        frame_done <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (chk_fail) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + 1'b1;
                    end else if (frame_evt) begin
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase

            if (frame_evt) begin
                addr_nxt <= '0;
                wr_addr  <= '0;
            end else if (state == LOCKED && active) begin
                wr_en   <= 1'b1;
                wr_addr <= addr_nxt;
                wr_data <= {s1_r, s1_g, s1_b};
                if (addr_nxt != ADDR_MAX)
                    addr_nxt <= addr_nxt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced raster (H 16/2/2/4, V 8/1/1/2).
module tb_vga_capture;

    localparam int HA = 16, HFP = 2, HS = 2, HBP = 4, HT = HA + HFP + HS + HBP;
    localparam int VA = 8,  VFP = 1, VS = 1, VBP = 2, VT = VA + VFP + VS + VBP;

    logic        clk = 1'b0;
    logic        rst_n, hsync, vsync;
    logic [7:0]  r, g, b;
    logic        wr_en, frame_done, locked;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic [7:0]  err_cnt;

    vga_capture #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .ADDR_W(19)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit const_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-side observer: totals only grow; the stimulus takes per-frame deltas.
    int          wr_total = 0, done_total = 0, addr_bad = 0, data_bad = 0, unlocked_wr = 0;
    int          lock_rise_cyc = 0, lock_fall_cyc = 0;
    logic [18:0] exp_addr = '0;
    logic [18:0] last_addr = '0;
    logic [11:0] last_data = '0;
    logic        prev_locked = 1'b0;

    function automatic logic [11:0] exp_data(input logic [18:0] a);
        int         y, x;
        logic [3:0] rn, gn;
        y  = int'(a) / HA;
        x  = int'(a) % HA;
        rn = 4'(y + VS + VBP);
        gn = 4'(x + HS + HBP);
        if (const_mode)
            return 12'hACE;
        return {rn, gn, 4'h9};
    endfunction

    always @(negedge clk) begin
        prev_locked <= locked;
        if (locked && !prev_locked) lock_rise_cyc <= cyc;
        if (!locked && prev_locked) lock_fall_cyc <= cyc;
        if (frame_done) begin
            done_total <= done_total + 1;
            exp_addr   <= '0;
        end
        if (wr_en) begin
            wr_total  <= wr_total + 1;
            last_addr <= wr_addr;
            last_data <= wr_data;
            exp_addr  <= wr_addr + 19'd1;
            if (wr_addr !== exp_addr) addr_bad <= addr_bad + 1;
            if (wr_data !== exp_data(wr_addr)) data_bad <= data_bad + 1;
            if (!locked) unlocked_wr <= unlocked_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int ls_cyc [0:15];
    int f_start, f_wr, f_done, f_abad, f_dbad;

    task automatic send_line(input int len, input int line, input bit vs_low, input int early);
        for (int p = 0; p < len; p++) begin
            @(negedge clk);
            if (p == 0) ls_cyc[line] = cyc;
            hsync = (p < HS) ? 1'b0 : 1'b1;
            vsync = (vs_low || (early > 0 && p >= len - early)) ? 1'b0 : 1'b1;
            if (const_mode) begin
                r = 8'hAB; g = 8'hCD; b = 8'hEF;
            end else begin
                r = {line[3:0], 4'h1};
                g = {p[3:0], 4'h2};
                b = 8'h93;
            end
        end
    endtask

    task automatic send_frame(input int nlines, input int short_line, input int early);
        int b_wr, b_done, b_ab, b_db;
        b_wr = wr_total; b_done = done_total; b_ab = addr_bad; b_db = data_bad;
        for (int l = 0; l < nlines; l++)
            send_line((l == short_line) ? HT - 1 : HT, l, l < VS, (l == nlines - 1) ? early : 0);
        @(posedge clk);
        #1;
        f_start = ls_cyc[0];
        f_wr    = wr_total - b_wr;
        f_done  = done_total - b_done;
        f_abad  = addr_bad - b_ab;
        f_dbad  = data_bad - b_db;
    endtask

    task automatic chk_good_frame(input string tag);
        chk({tag, "_wr"}, f_wr, HA * VA);
        chk({tag, "_done"}, f_done, 1);
        chk({tag, "_addr"}, f_abad, 0);
        chk({tag, "_data"}, f_dbad, 0);
        chk({tag, "_last_addr"}, last_addr, HA * VA - 1);
    endtask

    initial begin
        rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; r = '0; g = '0; b = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Acquisition: first frame event measures, second locks.
        send_frame(VT, -1, 0);
        chk("f1_locked", locked, 0);
        chk("f1_wr", f_wr, 0);
        send_frame(VT, -1, 0);
        chk("f2_lock_rise", lock_rise_cyc, f_start + 2);
        chk_good_frame("f2");
        send_frame(VT, -1, 0);
        chk_good_frame("f3");

        // Constant colour.
        const_mode = 1'b1;
        send_frame(VT, -1, 0);
        chk("const_wr", f_wr, HA * VA);
        chk("const_data_all", f_dbad, 0);
        chk("const_last_data", last_data, 12'hACE);
        const_mode = 1'b0;

        // One line 1 clock short: lock drops at the next hs_fall.
        send_frame(VT, 5, 0);
        chk("short_wr", f_wr, 3 * HA);
        chk("short_locked", locked, 0);
        chk("short_fall", lock_fall_cyc, ls_cyc[6] + 2);
        chk("short_err", err_cnt, 1);
        send_frame(VT, -1, 0);
        chk("short_measure_wr", f_wr, 0);
        chk("short_measure_done", f_done, 0);
        send_frame(VT, -1, 0);
        chk("short_relock_rise", lock_rise_cyc, f_start + 2);
        chk_good_frame("short_relock");

        // 13-line frame, then 11-line frame: each fails at the following frame event.
        send_frame(VT + 1, -1, 0);
        chk("long_wr", f_wr, HA * VA);
        send_frame(VT, -1, 0);
        chk("long_fail_wr", f_wr, 0);
        chk("long_fall", lock_fall_cyc, f_start + 2);
        chk("long_err", err_cnt, 2);
        send_frame(VT, -1, 0);
        chk("long_measure_wr", f_wr, 0);
        send_frame(VT, -1, 0);
        chk_good_frame("long_relock");
        send_frame(VT - 1, -1, 0);
        chk("shortv_wr", f_wr, HA * VA);
        send_frame(VT, -1, 0);
        chk("shortv_fail_wr", f_wr, 0);
        chk("shortv_fall", lock_fall_cyc, f_start + 2);
        chk("shortv_err", err_cnt, 3);
        send_frame(VT, -1, 0);
        send_frame(VT, -1, 0);
        chk_good_frame("shortv_relock");

        // vsync leading hsync by 10 clocks must frame exactly like coincident edges.
        send_frame(VT, -1, 10);
        chk_good_frame("coinc");
        send_frame(VT, -1, 0);
        chk_good_frame("early_vs");
        chk("early_vs_locked", locked, 1);
        chk("early_vs_err", err_cnt, 3);

        // Asynchronous reset in the middle of an active line.
        for (int l = 0; l < 5; l++) send_line(HT, l, l < VS, 0);
        send_line(11, 5, 1'b0, 0);
        chk("pre_rst_wr_en", wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_en", wr_en, 0);
        chk("arst_locked", locked, 0);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_err_cnt", err_cnt, 0);
        hsync = 1'b1; vsync = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(VT, -1, 0);
        chk("arst_f1_locked", locked, 0);
        send_frame(VT, -1, 0);
        chk("arst_lock_rise", lock_rise_cyc, f_start + 2);
        chk_good_frame("arst_relock");
        chk("no_unlocked_writes", unlocked_wr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
